// File: rtl/swap_undo.sv
// Adjacent-swap permutation engine with a LIFO undo log.
// Swaps are logged as their clamped index and replayed in reverse to restore identity.
module swap_undo #(
   parameter int K     = 3,
   parameter int Nm1   = 7,
   parameter int DEPTH = 16,
   parameter int LW    = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 swap_valid,
   input  logic [K-1:0]         swap_idx,
   output logic                 swap_ready,
   input  logic                 undo_req,
   output logic                 busy,
   output logic                 done,
   output logic [LW-1:0]        log_count,
   output logic                 identity,
   output logic [(Nm1+1)*K-1:0] x_out
);

   localparam int AW = LW - 1;
   localparam logic [K-1:0] TOP = K'(Nm1);

   typedef enum logic {IDLE, UNDO} state_t;

   state_t       state;
   logic [K-1:0] x       [0:Nm1];
   logic [K-1:0] log_mem [0:DEPTH-1];

   logic          accept;
   logic [AW-1:0] push_addr;
   logic [AW-1:0] top_addr;
   logic [K-1:0]  cmd_p;
   logic [K-1:0]  sel_p;
   logic [K-1:0]  sel_m;

   function automatic logic [K-1:0] clamp(input logic [K-1:0] i);
      return (i >= TOP) ? TOP : i;
   endfunction

   assign swap_ready = (state == IDLE) && !undo_req && (log_count < LW'(DEPTH));
   assign accept     = swap_valid && swap_ready;
   assign cmd_p      = clamp(swap_idx);
   assign push_addr  = log_count[AW-1:0];
   // Wraps to DEPTH-1 when the log is full, which is exactly the top entry.
   assign top_addr   = push_addr - 1'b1;
   assign sel_p      = (state == UNDO) ? log_mem[top_addr] : cmd_p;
   assign sel_m      = (sel_p == '0) ? TOP : sel_p - 1'b1;

   // NOTE: the log is plain storage guarded by log_count, so it carries no reset.
   always_ff @(posedge clock) begin
      if (accept)
         log_mem[push_addr] <= cmd_p;
   end

   // NOTE: non-blocking assignments let both halves of a swap read the pre-edge array.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         log_count <= '0;
         for (int j = 0; j <= Nm1; j++)
            x[j] <= K'(j);
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (undo_req) begin
                  if (log_count != '0) begin
                     state <= UNDO;
                     busy  <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end else if (accept) begin
                  x[sel_p]  <= x[sel_m];
                  x[sel_m]  <= x[sel_p];
                  log_count <= log_count + 1'b1;
               end
            end
            UNDO: begin
               x[sel_p]  <= x[sel_m];
               x[sel_m]  <= x[sel_p];
               log_count <= log_count - 1'b1;
               if (log_count == LW'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the default assignment up front keeps this purely combinational.
   always_comb begin
      identity = 1'b1;
      for (int j = 0; j <= Nm1; j++)
         if (x[j] != K'(j))
            identity = 1'b0;
   end

   for (genvar g = 0; g <= Nm1; g++) begin : g_flat
      assign x_out[g*K +: K] = x[g];
   end

endmodule

// File: doc/swap_undo.md
# swap_undo

Swap-permutation engine with an undo log. Holds the array x[0..Nm1], initialised to x[j]=j, and accepts one adjacent-swap command per cycle. Every accepted swap index is pushed onto a LIFO log. On request, the block replays the log in reverse and restores the identity permutation. It is the inverse-direction companion to the free-running swap model and is used to check that recorded swap sequences are exactly invertible.

## Interface
- K, 3, bits per element and per index
- Nm1, 7, highest array index; must be less than 1<<K
- DEPTH, 16, log entries; power of two
- LW, 5, log-count width; equals log2(DEPTH)+1
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- swap_valid  in  1  swap command present
- swap_idx  in  K  requested swap index i
- swap_ready  out  1  command accepted this cycle when swap_valid && swap_ready
- undo_req  in  1  request to unwind the entire log; sampled only in IDLE
- busy  out  1  high while in UNDO
- done  out  1  one-cycle pulse when an undo completes
- log_count  out  LW  number of valid log entries
- identity  out  1  combinational; 1 when x[j]==j for all j
- x_out  out  (Nm1+1)*K  flattened array; x[j] is at bits [j*K +: K]

## Operation
- Index mapping is combinational and is used both for commands and for popped entries:
  - p = (i >= Nm1) ? Nm1 : i
  - m = (p == 0) ? Nm1 : p-1
  - The swap exchanges x[p] and x[m]. Index 0 wraps, pairing x[0] with x[Nm1].
- The log stores p (the clamped value), K bits per entry. It is a stack with pointer log_count.
- Because each swap is its own inverse, undo reapplies the popped p.
- State machine:
  - IDLE
    - If undo_req=1 and log_count>0: go to UNDO. No swap is accepted this cycle.
    - If undo_req=1 and log_count==0: stay in IDLE and pulse done on the next cycle.
    - Else if swap_valid && swap_ready: apply the swap, push p, and increment log_count.
  - UNDO
    - Each cycle: pop the top entry, apply its swap, and decrement log_count.
    - When the pop takes log_count from 1 to 0: go to IDLE and pulse done.
    - swap_valid and undo_req are ignored.
- swap_ready = (state==IDLE) && !undo_req && (log_count < DEPTH). It is combinational, so undo wins over a simultaneous swap.
- Log full (log_count==DEPTH): swap_ready=0. Commands are held off, not dropped, and the array is unchanged.
- Reset values: state=IDLE, x[j]=j, log_count=0, done=0, busy=0, swap_ready=1, identity=1.
- Reset mid-undo: same as any reset. The array returns to identity, the log is cleared, and no done pulse is produced.

## Timing
- Accepted swap at edge t: x_out and log_count are updated after edge t (1-cycle latency).
- Undo accepted at edge t with n entries:
  - busy is high for exactly n cycles, after edges t .. t+n-1.
  - Pops occur at edges t+1 .. t+n.
  - done=1 for the single cycle after edge t+n, with busy=0, log_count=0 and identity=1.
- Undo with an empty log: done=1 for the single cycle after edge t, and there are no busy cycles.
- First new swap after an undo: may be accepted in the same cycle that done is high.
- identity and swap_ready are combinational from registered state plus undo_req. They add no extra latency.

## Test plan
- Reset, then hold idle:
  - x_out shows x[j]=j for j=0..7.
  - identity=1, log_count=0, swap_ready=1, busy=0, done=0.
- Swap i=3, then i=0:
  - After the first: x[2]=3, x[3]=2.
  - After the second: x[0]=7, x[7]=0.
  - log_count=2, identity=0.
- Instance with Nm1=5, swap i=6: clamps to p=5, swapping x[4] and x[5]. The logged entry is 5.
- 16 back-to-back swaps, then swap_valid held:
  - swap_ready falls after the 16th acceptance; the 17th command is not taken and the array is unchanged.
  - Assert undo_req: busy=1 for 16 cycles, then done pulses with identity=1 and log_count=0.
- undo_req and swap_valid in the same IDLE cycle with log_count=3:
  - The swap is not accepted.
  - busy for 3 cycles, then done and identity=1.
- Reset asserted during the 2nd cycle of an undo of 5 entries:
  - Next cycle: identity=1, log_count=0, busy=0.
  - done stays 0.
